tank_move_controller: RTL and testbench
=======================================

// Module: tank_move_controller
// PURPOSE
//  Sequences the on-screen position of one tank square: produces topLeftX/topLeftY for the
//  tank square object and its bitmap. Steps the tank once every FRAMES_PER_STEP frames in the
//  player-requested direction and clamps it to the screen. When the pixel-level collision
//  detector reports a hit, it restores the last collision-free position.
// PARAMETERS
//  INIT_X          11'd280  reset value of topLeftX (pixels)
//  INIT_Y          11'd400  reset value of topLeftY (pixels)
//  OBJECT_WIDTH_X  32       tank width; must match the square object instance
//  OBJECT_HEIGHT_Y 32       tank height; must match the square object instance
//  SCREEN_W        640      visible width (pixels)
//  SCREEN_H        480      visible height (pixels)
//  STEP            2        pixels moved per step
//  FRAMES_PER_STEP 2        frames per step, 1..15
// PORTS
//  clk          in   1   VGA pixel clock
//  resetN       in   1   asynchronous, active-low reset
//  startOfFrame in   1   one-cycle pulse at the start of each frame
//  dirUp        in   1   move-up request (level)
//  dirDown      in   1   move-down request (level)
//  dirLeft      in   1   move-left request (level)
//  dirRight     in   1   move-right request (level)
//  collision    in   1   tank pixel overlaps a wall or tank this frame (any-cycle pulse)
//  topLeftX     out  11  tank top-left X, registered
//  topLeftY     out  11  tank top-left Y, registered
//  heading      out  2   facing: 0=up 1=down 2=left 3=right, registered
//  moving       out  1   high while the FSM is in MOVE
// BEHAVIOUR
//  Reset (async, !resetN): topLeftX=INIT_X, topLeftY=INIT_Y, heading=0, moving=0,
//   state=IDLE, frame counter=0, hit latch=0, saved position=INIT. Applies mid-frame/mid-step.
//  Direction priority: up > down > left > right. The request is sampled only in the SOF cycle.
//  Hit latch: set by collision in any cycle; cleared in the cycle after startOfFrame.
//   A collision in the startOfFrame cycle itself counts for the frame that is ending.
//  FSM, evaluated only in the cycle where startOfFrame=1. All outputs update on the next edge
//   (latency 1 clk from SOF). Between SOF pulses, outputs hold.
//   Any state with hit latch=1 -> REVERT: position <= saved position, frame counter <= 0,
//    moving=0. This has top priority over motion.
//   IDLE: no request -> IDLE. Request -> MOVE: heading <= requested dir, frame counter <= 0.
//   MOVE: no request -> IDLE.
//    Request in a new dir -> heading updates at once, counter restarts at 0, no step this frame.
//    Same dir -> if counter==FRAMES_PER_STEP-1: saved <= current position, position steps by
//     STEP, counter <= 0. Otherwise counter++.
//   REVERT: always leaves after one frame. No request -> IDLE. Request -> MOVE, same rules as
//    IDLE->MOVE.
//  Clamp: X in [0, SCREEN_W-OBJECT_WIDTH_X], Y in [0, SCREEN_H-OBJECT_HEIGHT_Y].
//   Compute in 12-bit signed, then saturate at the bound; never wrap. A step at a bound leaves
//   the position unchanged and does not overwrite the saved position.
//  heading changes even when blocked (rotate in place).
// TESTING
//  1 Reset, no input, 10 SOFs -> X=280, Y=400, heading=0, moving=0 throughout.
//  2 dirRight held, FRAMES_PER_STEP=2, STEP=2, 6 SOFs -> X=286 after the 6th SOF, and X
//    changes exactly 1 clk after SOF #2, #4, #6.
//  3 Start X=4, dirLeft held -> X 2, 0, then stays 0. heading=2. No wrap to 2046.
//  4 Moving right; step to X=290 (saved=288), collision pulse mid-frame -> next SOF+1 clk
//    X=288, moving=0. Following SOF with dirRight -> moving=1.
//  5 dirUp and dirRight held together -> heading=0, Y decreases, X constant.
//  6 Assert resetN=0 between SOFs while X=300 -> X=280 immediately, asynchronously, with
//    no clk edge needed.

Source files
------------

// File: rtl/tank_move_controller_if.sv
// ---------------------------------------------------------------------------
// tank_move_controller_if
//   Groups the frame strobe, player requests, collision flag and the tank
//   position/heading outputs of the tank movement controller.
//   master : drives startOfFrame, dir*, collision; receives position/heading
//   slave  : the controller itself
// ---------------------------------------------------------------------------
interface tank_move_controller_if;
  logic        startOfFrame;
  logic        dirUp;
  logic        dirDown;
  logic        dirLeft;
  logic        dirRight;
  logic        collision;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic [1:0]  heading;
  logic        moving;

  modport master (
    output startOfFrame, dirUp, dirDown, dirLeft, dirRight, collision,
    input  topLeftX, topLeftY, heading, moving
  );

  modport slave (
    input  startOfFrame, dirUp, dirDown, dirLeft, dirRight, collision,
    output topLeftX, topLeftY, heading, moving
  );
endinterface

// File: rtl/tank_move_controller.sv
// ---------------------------------------------------------------------------
// tank_move_controller
//   Sequences the on-screen top-left position of one tank square. Once every
//   FRAMES_PER_STEP frames the tank steps STEP pixels in the requested
//   direction (up > down > left > right), clamped to the visible screen.
//   A collision seen during a frame restores the last collision-free
//   position at the next start of frame.
// Ports
//   clk     : VGA pixel clock
//   resetN  : asynchronous active-low reset
//   bus     : slave side of tank_move_controller_if
//             in : startOfFrame, dirUp/Down/Left/Right, collision
//             out: topLeftX, topLeftY, heading, moving (all registered)
// ---------------------------------------------------------------------------
module tank_move_controller #(
  parameter logic [10:0] INIT_X          = 11'd280,
  parameter logic [10:0] INIT_Y          = 11'd400,
  parameter int          OBJECT_WIDTH_X  = 32,
  parameter int          OBJECT_HEIGHT_Y = 32,
  parameter int          SCREEN_W        = 640,
  parameter int          SCREEN_H        = 480,
  parameter int          STEP            = 2,
  parameter int          FRAMES_PER_STEP = 2
) (
  input logic                    clk,
  input logic                    resetN,
  tank_move_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, MOVE, REVERT} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  localparam logic signed [11:0] MAX_X    = 12'(SCREEN_W - OBJECT_WIDTH_X);
  localparam logic signed [11:0] MAX_Y    = 12'(SCREEN_H - OBJECT_HEIGHT_Y);
  localparam logic signed [11:0] STEP_S   = 12'(STEP);
  localparam logic [3:0]         LAST_CNT = 4'(FRAMES_PER_STEP - 1);

  state_t      state, state_n;
  dir_t        heading, heading_n;
  logic [10:0] pos_x, pos_x_n, pos_y, pos_y_n;
  logic [10:0] saved_x, saved_x_n, saved_y, saved_y_n;
  logic [3:0]  cnt, cnt_n;
  logic        hit, hit_n;

  logic             req;
  dir_t             req_dir;
  logic signed [11:0] tgt_x, tgt_y;
  logic [10:0]      step_x, step_y;
  logic             blocked;

  // Direction request with fixed priority up > down > left > right.
  always_comb begin
    req     = bus.dirUp | bus.dirDown | bus.dirLeft | bus.dirRight;
    req_dir = DIR_RIGHT;
    if (bus.dirUp)        req_dir = DIR_UP;
    else if (bus.dirDown) req_dir = DIR_DOWN;
    else if (bus.dirLeft) req_dir = DIR_LEFT;
  end

  // Candidate step position: signed 12-bit so a step past 0 goes negative
  // instead of wrapping, then saturated at the screen bounds.
  always_comb begin
    tgt_x = signed'({1'b0, pos_x});
    tgt_y = signed'({1'b0, pos_y});
    unique case (heading)
      DIR_UP:    tgt_y = tgt_y - STEP_S;
      DIR_DOWN:  tgt_y = tgt_y + STEP_S;
      DIR_LEFT:  tgt_x = tgt_x - STEP_S;
      DIR_RIGHT: tgt_x = tgt_x + STEP_S;
    endcase
    if (tgt_x < 0)          tgt_x = '0;
    else if (tgt_x > MAX_X) tgt_x = MAX_X;
    if (tgt_y < 0)          tgt_y = '0;
    else if (tgt_y > MAX_Y) tgt_y = MAX_Y;
    step_x  = tgt_x[10:0];
    step_y  = tgt_y[10:0];
    // A step pinned at a bound is not a move: the saved position stays put.
    blocked = (step_x == pos_x) && (step_y == pos_y);
  end

  // Next-state / output logic, only active in the start-of-frame cycle.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned; that is what keeps this combinational block latch-free.
    state_n   = state;
    heading_n = heading;
    pos_x_n   = pos_x;
    pos_y_n   = pos_y;
    saved_x_n = saved_x;
    saved_y_n = saved_y;
    cnt_n     = cnt;
    // The latch clears right after SOF; a collision in the SOF cycle itself
    // is folded into this frame's decision below, not carried forward.
    hit_n     = bus.startOfFrame ? 1'b0 : (hit | bus.collision);

    if (bus.startOfFrame) begin
      if (hit | bus.collision) begin
        state_n = REVERT;
        pos_x_n = saved_x;
        pos_y_n = saved_y;
        cnt_n   = '0;
      end else begin
        unique case (state)
          IDLE, REVERT: begin
            if (req) begin
              state_n   = MOVE;
              heading_n = req_dir;
              cnt_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end
          MOVE: begin
            if (!req) begin
              state_n = IDLE;
            end else if (req_dir != heading) begin
              // Turn in place: the frame is spent rotating, no step.
              heading_n = req_dir;
              cnt_n     = '0;
            end else if (cnt == LAST_CNT) begin
              cnt_n = '0;
              if (!blocked) begin
                saved_x_n = pos_x;
                saved_y_n = pos_y;
                pos_x_n   = step_x;
                pos_y_n   = step_y;
              end
            end else begin
              cnt_n = cnt + 4'd1;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      heading <= DIR_UP;
      pos_x   <= INIT_X;
      pos_y   <= INIT_Y;
      saved_x <= INIT_X;
      saved_y <= INIT_Y;
      cnt     <= '0;
      hit     <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values,
      // independent of statement order.
      state   <= state_n;
      heading <= heading_n;
      pos_x   <= pos_x_n;
      pos_y   <= pos_y_n;
      saved_x <= saved_x_n;
      saved_y <= saved_y_n;
      cnt     <= cnt_n;
      hit     <= hit_n;
    end
  end

  assign bus.topLeftX = pos_x;
  assign bus.topLeftY = pos_y;
  assign bus.heading  = heading;
  assign bus.moving   = (state == MOVE);

endmodule

// File: tb/tb_tank_move_controller.sv
// ---------------------------------------------------------------------------
// tb_tank_move_controller
//   Directed testbench for tank_move_controller with default parameters
//   (INIT 280/400, STEP 2, FRAMES_PER_STEP 2, X max 608, Y max 448).
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, i.e. half a clock after the rising edge that updated them.
// ---------------------------------------------------------------------------
module tb_tank_move_controller;

  logic clk;
  logic resetN;
  int   tests_run;
  int   tests_failed;

  tank_move_controller_if bus ();

  tank_move_controller dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_dir(input bit up, input bit down, input bit left, input bit right);
    bus.dirUp    = up;
    bus.dirDown  = down;
    bus.dirLeft  = left;
    bus.dirRight = right;
  endtask

  task automatic do_reset();
    resetN           = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.collision    = 1'b0;
    set_dir(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
  endtask

  // One-cycle SOF pulse; on return the outputs are 1 clk past the SOF edge.
  task automatic sof(input bit col);
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    bus.collision    = col;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    bus.collision    = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sof(0);
      gap(2);
      tests_run++;
      if (bus.topLeftX !== 11'd280 || bus.topLeftY !== 11'd400 ||
          bus.heading !== 2'd0 || bus.moving !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle sof=%0d: x=%0d y=%0d hd=%0d mv=%0b, need x=280 y=400 hd=0 mv=0",
                 i, bus.topLeftX, bus.topLeftY, bus.heading, bus.moving);
      end
    end
  endtask

  // Entry SOF moves IDLE->MOVE; the following SOFs #1..#6 step on #2,#4,#6.
  task automatic test_step_timing();
    logic [10:0] pre, exp;
    do_reset();
    set_dir(0, 0, 0, 1);
    sof(0);
    tests_run++;
    if (bus.heading !== 2'd3 || bus.moving !== 1'b1 || bus.topLeftX !== 11'd280) begin
      tests_failed++;
      $display("FAIL step_entry: hd=%0d mv=%0b x=%0d, need hd=3 mv=1 x=280",
               bus.heading, bus.moving, bus.topLeftX);
    end
    gap(3);
    for (int i = 1; i <= 6; i++) begin
      pre = bus.topLeftX;
      sof(0);
      exp = (i % 2 == 0) ? pre + 11'd2 : pre;
      tests_run++;
      if (bus.topLeftX !== exp) begin
        tests_failed++;
        $display("FAIL step_sof%0d: x=%0d, need %0d", i, bus.topLeftX, exp);
      end
      gap(3);
      tests_run++;
      if (bus.topLeftX !== exp) begin
        tests_failed++;
        $display("FAIL step_hold%0d: x=%0d, need %0d", i, bus.topLeftX, exp);
      end
    end
    tests_run++;
    if (bus.topLeftX !== 11'd286 || bus.topLeftY !== 11'd400) begin
      tests_failed++;
      $display("FAIL step_final: x=%0d y=%0d, need x=286 y=400", bus.topLeftX, bus.topLeftY);
    end
  endtask

  // Walk left from 280 down to 4, then through the left bound.
  task automatic test_left_clamp();
    logic [10:0] exp_x [3];
    exp_x = '{11'd2, 11'd0, 11'd0};
    do_reset();
    set_dir(0, 0, 1, 0);
    sof(0);
    repeat (276) sof(0);
    tests_run++;
    if (bus.topLeftX !== 11'd4) begin
      tests_failed++;
      $display("FAIL clamp_reach4: x=%0d, need 4", bus.topLeftX);
    end
    for (int k = 0; k < 3; k++) begin
      sof(0);
      sof(0);
      tests_run++;
      if (bus.topLeftX !== exp_x[k] || bus.heading !== 2'd2) begin
        tests_failed++;
        $display("FAIL clamp_left%0d: x=%0d hd=%0d, need x=%0d hd=2",
                 k, bus.topLeftX, bus.heading, exp_x[k]);
      end
    end
    // Blocked steps at 0 must not have overwritten saved (=2, from the 2->0 step).
    set_dir(0, 0, 0, 0);
    gap(2);
    bus.collision = 1'b1;
    @(negedge clk);
    bus.collision = 1'b0;
    sof(0);
    tests_run++;
    if (bus.topLeftX !== 11'd2 || bus.moving !== 1'b0) begin
      tests_failed++;
      $display("FAIL clamp_saved: x=%0d mv=%0b, need x=2 mv=0", bus.topLeftX, bus.moving);
    end
  endtask

  task automatic test_collision_revert();
    do_reset();
    set_dir(0, 0, 0, 1);
    sof(0);
    repeat (10) sof(0);
    tests_run++;
    if (bus.topLeftX !== 11'd290) begin
      tests_failed++;
      $display("FAIL revert_pre: x=%0d, need 290", bus.topLeftX);
    end
    gap(3);
    bus.collision = 1'b1;
    @(negedge clk);
    bus.collision = 1'b0;
    gap(3);
    tests_run++;
    if (bus.topLeftX !== 11'd290 || bus.moving !== 1'b1) begin
      tests_failed++;
      $display("FAIL revert_hold: x=%0d mv=%0b, need x=290 mv=1", bus.topLeftX, bus.moving);
    end
    sof(0);
    tests_run++;
    if (bus.topLeftX !== 11'd288 || bus.moving !== 1'b0) begin
      tests_failed++;
      $display("FAIL revert_apply: x=%0d mv=%0b, need x=288 mv=0", bus.topLeftX, bus.moving);
    end
    gap(2);
    sof(0);
    tests_run++;
    if (bus.moving !== 1'b1 || bus.topLeftX !== 11'd288 || bus.heading !== 2'd3) begin
      tests_failed++;
      $display("FAIL revert_resume: mv=%0b x=%0d hd=%0d, need mv=1 x=288 hd=3",
               bus.moving, bus.topLeftX, bus.heading);
    end
  endtask

  // Collision in the SOF cycle counts for the ending frame; latch then clears.
  task automatic test_sof_collision();
    do_reset();
    set_dir(0, 0, 0, 1);
    sof(0);
    sof(0);
    sof(0);
    tests_run++;
    if (bus.topLeftX !== 11'd282) begin
      tests_failed++;
      $display("FAIL sofcol_pre: x=%0d, need 282", bus.topLeftX);
    end
    sof(1);
    tests_run++;
    if (bus.topLeftX !== 11'd280 || bus.moving !== 1'b0) begin
      tests_failed++;
      $display("FAIL sofcol_revert: x=%0d mv=%0b, need x=280 mv=0", bus.topLeftX, bus.moving);
    end
    gap(2);
    sof(0);
    tests_run++;
    if (bus.topLeftX !== 11'd280 || bus.moving !== 1'b1) begin
      tests_failed++;
      $display("FAIL sofcol_cleared: x=%0d mv=%0b, need x=280 mv=1", bus.topLeftX, bus.moving);
    end
  endtask

  task automatic test_priority();
    do_reset();
    set_dir(1, 0, 0, 1);
    sof(0);
    sof(0);
    sof(0);
    tests_run++;
    if (bus.heading !== 2'd0 || bus.topLeftY !== 11'd398 || bus.topLeftX !== 11'd280) begin
      tests_failed++;
      $display("FAIL priority_up: hd=%0d x=%0d y=%0d, need hd=0 x=280 y=398",
               bus.heading, bus.topLeftX, bus.topLeftY);
    end
    sof(0);
    sof(0);
    tests_run++;
    if (bus.topLeftY !== 11'd396 || bus.topLeftX !== 11'd280) begin
      tests_failed++;
      $display("FAIL priority_up2: x=%0d y=%0d, need x=280 y=396", bus.topLeftX, bus.topLeftY);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_dir(0, 0, 0, 1);
    sof(0);
    repeat (20) sof(0);
    tests_run++;
    if (bus.topLeftX !== 11'd300) begin
      tests_failed++;
      $display("FAIL async_pre: x=%0d, need 300", bus.topLeftX);
    end
    @(posedge clk);
    #2;
    resetN = 1'b0;
    #1;
    tests_run++;
    if (bus.topLeftX !== 11'd280 || bus.moving !== 1'b0 || bus.heading !== 2'd0) begin
      tests_failed++;
      $display("FAIL async_reset: x=%0d mv=%0b hd=%0d, need x=280 mv=0 hd=0",
               bus.topLeftX, bus.moving, bus.heading);
    end
    @(negedge clk);
    resetN = 1'b1;
    set_dir(0, 0, 0, 0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_step_timing();
    test_left_clamp();
    test_collision_revert();
    test_sof_collision();
    test_priority();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
